// File: rtl/avalon_st_checker_pkg.sv
// Shared definitions for the passive Avalon-ST protocol checker:
// violation bit positions and the error vector type.
package avalon_st_checker_pkg;

    // Bit positions inside err_flags
    localparam int SOP_IN_PKT  = 32'd0;
    localparam int EOP_NO_PKT  = 32'd1;
    localparam int DATA_NO_PKT = 32'd2;
    localparam int EMPTY_NZ    = 32'd3;
    localparam int CHAN_RANGE  = 32'd4;
    localparam int HOLD        = 32'd5;

    localparam int ERR_N = 32'd6;

    typedef logic [ERR_N-1:0] err_vec_t;

endpackage : avalon_st_checker_pkg

// File: rtl/avalon_st_sat_cnt.sv
// Saturating event counter. A clear that coincides with an increment
// leaves the counter at one, so the event that arrived with the clear
// is not lost.
module avalon_st_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};

    // Count register: clear-then-apply, hold at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= CNT_ZERO;
        end else if (clr) begin
            cnt <= inc ? CNT_ONE : CNT_ZERO;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= cnt;
        end
    end

endmodule : avalon_st_sat_cnt

// File: rtl/avalon_st_checker.sv
// Passive Avalon-ST protocol checker. Observes one stream link, tracks
// packet framing per channel and reports violations through sticky flags
// and a one-cycle strobe. All outputs are registered, so an event in
// cycle N shows up in cycle N+1.
module avalon_st_checker
    import avalon_st_checker_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int EMPTY_W    = 3,
    parameter int CHANNEL_W  = 8,
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 32,
    parameter int HOLD_CHECK = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    data,
    input  logic                 sop,
    input  logic                 eop,
    input  logic                 val,
    input  logic                 ready,
    input  logic [EMPTY_W-1:0]   empty,
    input  logic [CHANNEL_W-1:0] channel,
    input  logic                 clear,
    output err_vec_t             err_flags,
    output logic                 err_stb,
    output logic [CHANNELS-1:0]  in_pkt,
    output logic [CNT_W-1:0]     pkt_cnt,
    output logic [CNT_W-1:0]     beat_cnt
);

    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    // Everything that must stay stable while a beat is stalled
    localparam int REF_W = DATA_W + EMPTY_W + CHANNEL_W + 2;
    localparam logic [CHANNEL_W:0] CHAN_LIM = (CHANNEL_W + 1)'(CHANNELS);

    logic                acc_s;
    logic                chan_ok_s;
    logic                cur_pkt_s;
    logic                stall_s;
    logic [IDX_W-1:0]    ch_idx_s;
    logic [REF_W-1:0]    tap_s;
    logic [REF_W-1:0]    hold_ref_r;
    logic                hold_vld_r;
    err_vec_t            err_s;
    logic [CHANNELS-1:0] in_pkt_nxt_s;

    assign acc_s     = val & ready;
    assign stall_s   = val & ~ready;
    assign chan_ok_s = ({1'b0, channel} < CHAN_LIM);
    assign ch_idx_s  = channel[IDX_W-1:0];
    assign cur_pkt_s = in_pkt[ch_idx_s];
    assign tap_s     = {data, sop, eop, empty, channel};

    // Violation detection and next per-channel framing state
    always_comb begin
        err_s        = '0;
        in_pkt_nxt_s = in_pkt;

        // Framing only moves on accepted beats addressed to a tracked channel
        if (acc_s && chan_ok_s) begin
            if (sop) begin
                if (cur_pkt_s) begin
                    err_s[SOP_IN_PKT] = 1'b1;
                end else begin
                    err_s[SOP_IN_PKT] = 1'b0;
                end
                // A restart or a fresh start: single-beat packets leave it idle
                in_pkt_nxt_s[ch_idx_s] = ~eop;
            end else if (eop) begin
                if (!cur_pkt_s) begin
                    err_s[EOP_NO_PKT] = 1'b1;
                end else begin
                    err_s[EOP_NO_PKT] = 1'b0;
                end
                in_pkt_nxt_s[ch_idx_s] = 1'b0;
            end else begin
                // Stray data on an idle channel is flagged, framing untouched
                if (!cur_pkt_s) begin
                    err_s[DATA_NO_PKT] = 1'b1;
                end else begin
                    err_s[DATA_NO_PKT] = 1'b0;
                end
            end
        end else begin
            in_pkt_nxt_s = in_pkt;
        end

        if (acc_s && !eop && (empty != {EMPTY_W{1'b0}})) begin
            err_s[EMPTY_NZ] = 1'b1;
        end else begin
            err_s[EMPTY_NZ] = 1'b0;
        end

        if (acc_s && !chan_ok_s) begin
            err_s[CHAN_RANGE] = 1'b1;
        end else begin
            err_s[CHAN_RANGE] = 1'b0;
        end

        // A stalled beat must be presented again unchanged
        if ((HOLD_CHECK != 0) && hold_vld_r && (!val || (tap_s != hold_ref_r))) begin
            err_s[HOLD] = 1'b1;
        end else begin
            err_s[HOLD] = 1'b0;
        end
    end

    // Capture the stalled beat as the reference for the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_vld_r <= 1'b0;
            hold_ref_r <= {REF_W{1'b0}};
        end else if (stall_s) begin
            hold_vld_r <= 1'b1;
            hold_ref_r <= tap_s;
        end else begin
            hold_vld_r <= 1'b0;
            hold_ref_r <= hold_ref_r;
        end
    end

    // Sticky flags, strobe and framing state; clear wipes flags before new ones land
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flags <= '0;
            err_stb   <= 1'b0;
            in_pkt    <= {CHANNELS{1'b0}};
        end else begin
            err_flags <= (clear ? err_vec_t'(0) : err_flags) | err_s;
            err_stb   <= |err_s;
            in_pkt    <= in_pkt_nxt_s;
        end
    end

    avalon_st_sat_cnt #(.W(CNT_W)) u_beat_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (acc_s),
        .cnt (beat_cnt)
    );

    avalon_st_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (acc_s & eop),
        .cnt (pkt_cnt)
    );

endmodule : avalon_st_checker

// File: tb/tb_avalon_st_checker.sv
// Scoreboard bench for avalon_st_checker. The stimulus pushes one
// hand-computed expectation per driven cycle; a monitor pops one entry per
// clock after the edge and compares the fields selected by its mask.
// A second instance (4-bit counters, hold rule off) shares the stimulus.
module tb_avalon_st_checker;
    import avalon_st_checker_pkg::*;

    logic        clk;
    logic        rst;
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic        val;
    logic        ready;
    logic [2:0]  empty;
    logic [7:0]  channel;
    logic        clear;

    err_vec_t    err_flags;
    logic        err_stb;
    logic [3:0]  in_pkt;
    logic [31:0] pkt_cnt;
    logic [31:0] beat_cnt;

    err_vec_t    err_flags2;
    logic        err_stb2;
    logic [3:0]  in_pkt2;
    logic [3:0]  pkt_cnt2;
    logic [3:0]  beat_cnt2;

    avalon_st_checker #(
        .DATA_W(64), .EMPTY_W(3), .CHANNEL_W(8), .CHANNELS(4), .CNT_W(32), .HOLD_CHECK(1)
    ) dut (
        .clk(clk), .rst(rst), .data(data), .sop(sop), .eop(eop), .val(val), .ready(ready),
        .empty(empty), .channel(channel), .clear(clear), .err_flags(err_flags),
        .err_stb(err_stb), .in_pkt(in_pkt), .pkt_cnt(pkt_cnt), .beat_cnt(beat_cnt)
    );

    avalon_st_checker #(
        .DATA_W(64), .EMPTY_W(3), .CHANNEL_W(8), .CHANNELS(4), .CNT_W(4), .HOLD_CHECK(0)
    ) dut2 (
        .clk(clk), .rst(rst), .data(data), .sop(sop), .eop(eop), .val(val), .ready(ready),
        .empty(empty), .channel(channel), .clear(clear), .err_flags(err_flags2),
        .err_stb(err_stb2), .in_pkt(in_pkt2), .pkt_cnt(pkt_cnt2), .beat_cnt(beat_cnt2)
    );

    // Field-select bits of an expectation
    localparam logic [6:0] MF  = 7'h01;  // err_flags
    localparam logic [6:0] MS  = 7'h02;  // err_stb
    localparam logic [6:0] MI  = 7'h04;  // in_pkt
    localparam logic [6:0] MP  = 7'h08;  // pkt_cnt
    localparam logic [6:0] MB  = 7'h10;  // beat_cnt
    localparam logic [6:0] MF2 = 7'h20;  // err_flags of second instance
    localparam logic [6:0] MB2 = 7'h40;  // beat_cnt of second instance

    typedef struct {
        string       name;
        logic [6:0]  mask;
        logic [5:0]  flags;
        logic        stb;
        logic [3:0]  inpkt;
        logic [31:0] pkt;
        logic [31:0] beat;
        logic [5:0]  flags2;
        logic [3:0]  beat2;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t ex(input string nm, input logic [6:0] m, input logic [5:0] f,
                                input logic s, input logic [3:0] ip, input logic [31:0] p,
                                input logic [31:0] b, input logic [5:0] f2, input logic [3:0] b2);
        exp_t x;
        x.name = nm; x.mask = m; x.flags = f; x.stb = s; x.inpkt = ip;
        x.pkt = p; x.beat = b; x.flags2 = f2; x.beat2 = b2;
        return x;
    endfunction

    function automatic exp_t none();
        return ex("", 7'h00, 6'h00, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0);
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
    endtask

    // Drive one cycle at the falling edge and queue its expected outcome
    task automatic drv(input logic v, input logic r, input logic s, input logic e,
                       input logic [7:0] ch, input logic [2:0] em, input logic [63:0] d,
                       input logic clr, input logic rs, input exp_t x);
        @(negedge clk);
        val = v; ready = r; sop = s; eop = e; channel = ch; empty = em;
        data = d; clear = clr; rst = rs;
        q.push_back(x);
    endtask

    task automatic idle(input logic clr, input logic rs, input exp_t x);
        drv(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 3'd0, 64'd0, clr, rs, x);
    endtask

    task automatic beat(input logic s, input logic e, input logic [7:0] ch,
                        input logic [2:0] em, input logic [63:0] d, input exp_t x);
        drv(1'b1, 1'b1, s, e, ch, em, d, 1'b0, 1'b0, x);
    endtask

    // Monitor: one expectation per clock, checked just after the edge
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                x = q.pop_front();
                if (x.mask[0]) cmp({x.name, ".err_flags"}, 32'(err_flags), 32'(x.flags));
                if (x.mask[1]) cmp({x.name, ".err_stb"},   32'(err_stb),   32'(x.stb));
                if (x.mask[2]) cmp({x.name, ".in_pkt"},    32'(in_pkt),    32'(x.inpkt));
                if (x.mask[3]) cmp({x.name, ".pkt_cnt"},   pkt_cnt,        x.pkt);
                if (x.mask[4]) cmp({x.name, ".beat_cnt"},  beat_cnt,       x.beat);
                if (x.mask[5]) cmp({x.name, ".err_flags2"}, 32'(err_flags2), 32'(x.flags2));
                if (x.mask[6]) cmp({x.name, ".beat_cnt2"}, 32'(beat_cnt2), 32'(x.beat2));
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t x;
        rst = 1'b1; val = 1'b0; ready = 1'b0; sop = 1'b0; eop = 1'b0;
        data = 64'd0; empty = 3'd0; channel = 8'd0; clear = 1'b0;

        // Reset state
        idle(1'b0, 1'b1, none());
        idle(1'b0, 1'b1, ex("reset", 7'h7f, 6'h00, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0));

        // Clean packet on channel 2, eop carries empty=5
        beat(1'b1, 1'b0, 8'd2, 3'd0, 64'h11, ex("t1_sop", MF | MI | MB, 6'h00, 1'b0, 4'h4, 32'd0, 32'd1, 6'h00, 4'h0));
        beat(1'b0, 1'b0, 8'd2, 3'd0, 64'h12, none());
        beat(1'b0, 1'b0, 8'd2, 3'd0, 64'h13, none());
        beat(1'b0, 1'b1, 8'd2, 3'd5, 64'h14, ex("t1_eop", MF | MS | MI | MP | MB | MB2, 6'h00, 1'b0, 4'h0, 32'd1, 32'd4, 6'h00, 4'd4));

        // SOP inside a packet on channel 1, then clear keeps framing
        beat(1'b1, 1'b0, 8'd1, 3'd0, 64'h21, ex("t2_sop", MI, 6'h00, 1'b0, 4'h2, 32'd0, 32'd0, 6'h00, 4'h0));
        beat(1'b1, 1'b0, 8'd1, 3'd0, 64'h22, ex("t2_resop", MF | MS | MI | MB, 6'h01, 1'b1, 4'h2, 32'd0, 32'd6, 6'h00, 4'h0));
        idle(1'b0, 1'b0, ex("t2_stb_low", MF | MS, 6'h01, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0));
        idle(1'b1, 1'b0, ex("t2_clear", MF | MI | MP | MB | MF2 | MB2, 6'h00, 1'b0, 4'h2, 32'd0, 32'd0, 6'h00, 4'h0));

        // Idle channel 0: eop alone, data alone, then a legal single-beat packet
        beat(1'b0, 1'b1, 8'd0, 3'd0, 64'h31, ex("t3_eop_idle", MS | MP, 6'h00, 1'b1, 4'h0, 32'd1, 32'd0, 6'h00, 4'h0));
        beat(1'b0, 1'b0, 8'd0, 3'd0, 64'h32, ex("t3_data_idle", MF | MS | MB, 6'h06, 1'b1, 4'h0, 32'd0, 32'd2, 6'h00, 4'h0));
        beat(1'b1, 1'b1, 8'd0, 3'd0, 64'h33, ex("t3_single", MF | MS | MI | MP | MB, 6'h06, 1'b0, 4'h2, 32'd2, 32'd3, 6'h00, 4'h0));

        // Channel out of range, then non-eop beat with nonzero empty
        beat(1'b0, 1'b1, 8'd1, 3'd0, 64'h41, ex("t4_close1", MI, 6'h00, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0));
        idle(1'b1, 1'b0, none());
        beat(1'b1, 1'b0, 8'd7, 3'd0, 64'h42, ex("t4_chan", MF | MS | MI | MB, 6'h10, 1'b1, 4'h0, 32'd0, 32'd1, 6'h00, 4'h0));
        idle(1'b1, 1'b0, none());
        beat(1'b1, 1'b0, 8'd3, 3'd1, 64'h43, ex("t4_empty", MF | MI | MB, 6'h08, 1'b0, 4'h8, 32'd0, 32'd1, 6'h00, 4'h0));
        beat(1'b0, 1'b1, 8'd3, 3'd0, 64'h44, ex("t4_close3", MF | MI | MP, 6'h08, 1'b0, 4'h0, 32'd1, 32'd0, 6'h00, 4'h0));

        // Clear together with a violating eop beat: the new event survives
        drv(1'b1, 1'b1, 1'b0, 1'b1, 8'd2, 3'd0, 64'h45, 1'b1, 1'b0,
            ex("clr_coinc", MF | MP | MB | MF2, 6'h02, 1'b0, 4'h0, 32'd1, 32'd1, 6'h02, 4'h0));

        // Stall for three cycles with data changing in the second
        idle(1'b1, 1'b0, none());
        drv(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 64'hA0, 1'b0, 1'b0, none());
        drv(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 64'hA1, 1'b0, 1'b0,
            ex("hold_set", MF | MS | MF2, 6'h20, 1'b1, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0));
        drv(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 3'd0, 64'hA1, 1'b0, 1'b0,
            ex("hold_stb_low", MS | MB, 6'h00, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0));
        beat(1'b1, 1'b0, 8'd0, 3'd0, 64'hA1, ex("hold_accept", MF | MI | MB, 6'h20, 1'b0, 4'h1, 32'd0, 32'd1, 6'h00, 4'h0));
        beat(1'b0, 1'b1, 8'd0, 3'd0, 64'hA2, ex("hold_close", MI | MF2, 6'h00, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0));

        // Saturation of the 4-bit counters in the second instance
        idle(1'b1, 1'b0, none());
        for (int i = 1; i <= 20; i++) begin
            if (i == 15)
                x = ex("sat15", MB2, 6'h00, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'd15);
            else if (i == 20)
                x = ex("sat20", MF | MI | MP | MB | MB2, 6'h00, 1'b0, 4'h0, 32'd20, 32'd20, 6'h00, 4'd15);
            else
                x = none();
            beat(1'b1, 1'b1, 8'd0, 3'd0, 64'(i), x);
        end

        // Reset in the middle of a packet drops framing
        beat(1'b1, 1'b0, 8'd1, 3'd0, 64'h71, ex("t7_sop", MI, 6'h00, 1'b0, 4'h2, 32'd0, 32'd0, 6'h00, 4'h0));
        idle(1'b0, 1'b1, ex("t7_reset", MF | MS | MI | MP | MB, 6'h00, 1'b0, 4'h0, 32'd0, 32'd0, 6'h00, 4'h0));
        beat(1'b0, 1'b0, 8'd1, 3'd0, 64'h72, ex("t7_data", MF | MS | MI | MB, 6'h04, 1'b1, 4'h0, 32'd0, 32'd1, 6'h00, 4'h0));
        idle(1'b0, 1'b0, none());

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 10; i++) begin
            if (q.size() > 0) @(posedge clk);
        end
        #2;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_avalon_st_checker

// File: doc/avalon_st_checker.md
# avalon_st_checker

Synthesisable, passive Avalon-ST protocol checker for one stream: taps a `snk`/`src` link without driving it, tracks packet framing independently per channel, and flags violations through sticky error bits plus a one-cycle strobe. It generalises the simulation-only SOP/EOP counter in our Avalon-ST interface. It adds multichannel tracking, handshake-hold, empty and channel-range rules, and saturating traffic counters, so protocol checks survive into FPGA builds and can be read by debug logic.

## Interface
- `DATA_W`, 64, stream data width
- `EMPTY_W`, 3, empty field width
- `CHANNEL_W`, 8, channel field width
- `CHANNELS`, 4, number of tracked channels; must be ≤ 2^`CHANNEL_W`
- `CNT_W`, 32, width of traffic counters
- `HOLD_CHECK`, 1, 1 enables the stall-hold rule; 0 disables it (`HOLD` never set)

- `clk`  in  1  stream clock
- `rst`  in  1  synchronous, active-high reset
- `data`  in  `DATA_W`  tapped data
- `sop`, `eop`, `val`, `ready`  in  1 each  tapped framing and handshake
- `empty`  in  `EMPTY_W`  tapped empty
- `channel`  in  `CHANNEL_W`  tapped channel
- `clear`  in  1  clears sticky errors and counters; packet state is kept
- `err_flags`  out  6  sticky violation bits, indices per package
- `err_stb`  out  1  pulses one cycle after any violating cycle
- `in_pkt`  out  `CHANNELS`  per-channel "inside packet" state
- `pkt_cnt`  out  `CNT_W`  accepted EOPs, saturating
- `beat_cnt`  out  `CNT_W`  accepted beats, saturating

## Operation
- Accepted beat: `val && ready`. Packet-framing rules are evaluated only on accepted beats with an in-range channel.
- `SOP_IN_PKT`: `sop` on a channel with `in_pkt`=1. Treated as a restart: `in_pkt` stays 1, or goes to 0 if `eop` is also set.
- `EOP_NO_PKT`: `eop && !sop` on a channel with `in_pkt`=0. `in_pkt` stays 0.
- `DATA_NO_PKT`: `!sop && !eop` on a channel with `in_pkt`=0. Beat is ignored for framing.
- `EMPTY_NZ`: accepted beat with `!eop && empty!=0`.
- `CHAN_RANGE`: accepted beat with `channel >= CHANNELS`. No channel state is touched.
- `HOLD`: the previous cycle had `val && !ready`, and this cycle `val` dropped or any of `data`/`sop`/`eop`/`empty`/`channel` changed.
- Legal transitions:
  - `sop` with `in_pkt`=0 sets `in_pkt`.
  - `eop` clears `in_pkt`.
  - `sop && eop` on an idle channel is a single-beat packet; `in_pkt` stays 0 and `pkt_cnt` increments.
- Counters:
  - `beat_cnt` increments on every accepted beat, including erroneous ones.
  - `pkt_cnt` increments on every accepted `eop`.
  - Both hold at all-ones.
- `clear` zeroes `err_flags`, `pkt_cnt` and `beat_cnt`. If `clear` coincides with a new violation or beat, the new event is applied after the clear: the flag ends at 1 and the counter ends at 1.
- Several violations in one cycle set all corresponding bits and produce a single `err_stb` pulse.

## Timing
- All outputs are registered. A violation or beat in cycle N is visible in `err_flags`, `err_stb`, `in_pkt` and the counters in cycle N+1.
- Reset values: `err_flags`=0, `err_stb`=0, `in_pkt`=0, `pkt_cnt`=0, `beat_cnt`=0. The hold-reference registers are invalidated, so no `HOLD` can fire in the first cycle after reset.
- Reset mid-packet drops all packet state. A continuation beat after reset therefore reports `DATA_NO_PKT`.
- The hold reference is captured every cycle with `val && !ready` and compared in the next cycle.

## Structure
- Package `avalon_st_checker_pkg`:
  - error index localparams: `SOP_IN_PKT`=0, `EOP_NO_PKT`=1, `DATA_NO_PKT`=2, `EMPTY_NZ`=3, `CHAN_RANGE`=4, `HOLD`=5
  - `ERR_N`=6
  - typedef `err_vec_t` (`logic [ERR_N-1:0]`)
- Sub-module `avalon_st_sat_cnt`: parameter `W`; inputs `clk`, `rst`, `clr`, `inc`; output `cnt`. Instantiated twice.
- Per-channel state is a `CHANNELS`-bit register array inside the top module.

## Test plan
- Ch 2, with `ready`=1 throughout: sop beat, 2 data beats, eop beat with `empty`=5 → no errors, `in_pkt`[2] goes 1 then back to 0, `pkt_cnt`=1, `beat_cnt`=4.
- Ch 1 in a packet, then `sop` again on ch 1 → `err_flags`=0x01, `err_stb` for one cycle, `in_pkt`[1] stays 1. Then `clear` → flags 0, counters 0, `in_pkt`[1] still 1.
- Idle ch 0: `eop` alone, then a data beat → `err_flags`=0x06. A following `sop`+`eop` beat on ch 0 → `pkt_cnt` increments and no new flag is set.
- `channel`=7 with `CHANNELS`=4 → `CHAN_RANGE` set, `in_pkt`=0. Separately, a non-eop beat with `empty`=1 → `EMPTY_NZ` set.
- `val`=1 with `ready`=0 for 3 cycles, `data` changes in cycle 2 → `HOLD` set. Repeat with `HOLD_CHECK`=0 → no flag.
- Preload `beat_cnt` to all-ones with `CNT_W`=4: 20 beats → `beat_cnt`=15. Assert `rst` mid-packet, then send a data beat → `DATA_NO_PKT`.
